// File: rtl/pbit_rng_pkg.sv
// Shared types, default tap masks and LFSR step function for pbit_rng_bank.
// Optional build macro: PBIT_RNG_ZERO_INSERT_EN (see pbit_lfsr_core).
package pbit_rng_pkg;

   typedef enum logic {WARM, RUN} rng_state_e;

   localparam logic [31:0] TAPS_8  = 32'h0000_00B8;
   localparam logic [31:0] TAPS_16 = 32'h0000_D008;
   localparam logic [31:0] TAPS_24 = 32'h00E1_0000;
   localparam logic [31:0] TAPS_32 = 32'h8020_0003;

   // XNOR Fibonacci step on the low w bits; upper bits return zero.
   function automatic logic [31:0] lfsr_next(
      input logic [31:0] s,
      input logic [31:0] taps,
      input int unsigned w
   );
      logic [31:0] m;
      logic        fb;
      m  = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      fb = ~^(s & taps & m);
      return ((s << 1) | {31'd0, fb}) & m;
   endfunction

endpackage

// File: rtl/pbit_lfsr_core.sv
// One XNOR LFSR channel with load and step controls.
// PBIT_RNG_ZERO_INSERT_EN adds a one-shot all-zero word before state 'h3.
module pbit_lfsr_core
   import pbit_rng_pkg::*;
#(
   parameter int unsigned       WIDTH = 32,
   parameter logic [31:0]       TAPS  = 32'h8020_0003,
   parameter logic [WIDTH-1:0]  SEED  = WIDTH'(1)
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             step,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] state;
   logic [31:0]      nxt32;
   logic [WIDTH-1:0] nxt;

   assign nxt32 = lfsr_next(32'(state), TAPS, WIDTH);
   assign nxt   = nxt32[WIDTH-1:0];

`ifdef PBIT_RNG_ZERO_INSERT_EN
   logic zero_q;
   logic done_q;

   // Hold one step on the way to 'h3 so the all-zero word appears once.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= SEED;
         zero_q <= 1'b0;
         done_q <= 1'b0;
      end else if (load) begin
         state  <= load_val;
         zero_q <= 1'b0;
         done_q <= 1'b0;
      end else if (step) begin
         if (zero_q) begin
            zero_q <= 1'b0;
            state  <= nxt;
         end else if (nxt == WIDTH'(3) && !done_q) begin
            zero_q <= 1'b1;
            done_q <= 1'b1;
         end else begin
            state <= nxt;
         end
      end
   end

   assign q = zero_q ? '0 : state;
`else
   always_ff @(posedge clk) begin
      if (rst)       state <= SEED;
      else if (load) state <= load_val;
      else if (step) state <= nxt;
   end

   assign q = state;
`endif

endmodule

// File: rtl/pbit_rng_bank.sv
// Multi-channel XNOR LFSR word source with warm-up, reseed and lockup guard.
// Optional build macro: PBIT_RNG_ZERO_INSERT_EN (forwarded to each core).
module pbit_rng_bank
   import pbit_rng_pkg::*;
#(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned NUM_CH      = 4,
   parameter logic [31:0] TAPS        = 32'h8020_0003,
   parameter logic [31:0] SEED_BASE   = 32'd1,
   parameter logic [31:0] SEED_STRIDE = 32'h9E37_79B9,
   parameter int unsigned WARMUP      = 16,
   localparam int unsigned CW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    seed_load,
   input  logic [CW-1:0]           seed_ch,
   input  logic [WIDTH-1:0]        seed_data,
   output logic [NUM_CH*WIDTH-1:0] rnd_out,
   output logic                    rnd_valid,
   output logic [NUM_CH-1:0]       lockup_flag
);

   localparam logic [WIDTH-1:0] ONES = '1;
   localparam logic [WIDTH-1:0] SAFE = {ONES[WIDTH-2:0], 1'b0};
   localparam logic [15:0]      WU   = 16'(WARMUP);

   rng_state_e       fsm;
   logic [15:0]      cnt;
   logic             load_ok;
   logic             step_all;
   logic             seed_bad;
   logic [WIDTH-1:0] seed_safe;

   assign load_ok   = seed_load && (32'(seed_ch) < NUM_CH);
   assign seed_bad  = (seed_data == ONES);
   assign seed_safe = seed_bad ? SAFE : seed_data;
   assign step_all  = (fsm == WARM) || en;

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm       <= (WARMUP == 0) ? RUN : WARM;
         cnt       <= WU;
         rnd_valid <= (WARMUP == 0);
      end else if (load_ok && WARMUP != 0) begin
         fsm       <= WARM;
         cnt       <= WU;
         rnd_valid <= 1'b0;
      end else if (fsm == WARM) begin
         if (cnt == 16'd1) begin
            fsm       <= RUN;
            rnd_valid <= 1'b1;
         end else begin
            cnt <= cnt - 16'd1;
         end
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      localparam logic [31:0]      RAW  = SEED_BASE + 32'(i) * SEED_STRIDE;
      localparam logic [WIDTH-1:0] S0   = RAW[WIDTH-1:0];
      localparam logic [WIDTH-1:0] SEED = (S0 == ONES) ? SAFE : S0;

      logic ld;
      logic lk;

      assign ld = load_ok && (32'(seed_ch) == i);

      pbit_lfsr_core #(
         .WIDTH (WIDTH),
         .TAPS  (TAPS),
         .SEED  (SEED)
      ) u_core (
         .clk      (clk),
         .rst      (rst),
         .step     (step_all),
         .load     (ld),
         .load_val (seed_safe),
         .q        (rnd_out[i*WIDTH +: WIDTH])
      );

      always_ff @(posedge clk) begin
         if (rst)                lk <= 1'b0;
         else if (ld && seed_bad) lk <= 1'b1;
      end

      assign lockup_flag[i] = lk;
   end

endmodule

// File: tb/tb_pbit_rng_bank.sv
// Self-checking bench for pbit_rng_bank: WARMUP=16 and WARMUP=0 instances.
// Honours PBIT_RNG_ZERO_INSERT_EN in its reference model.
module tb_pbit_rng_bank;

   localparam logic [31:0] TAPS = 32'h8020_0003;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         en = 1'b0;
   logic         seed_load = 1'b0;
   logic [1:0]   seed_ch = 2'd0;
   logic [31:0]  seed_data = 32'd0;
   logic [127:0] out_w, out_z;
   logic         val_w, val_z;
   logic [3:0]   lk_w, lk_z;

   always #5 clk = ~clk;

   pbit_rng_bank #(.WARMUP(16)) u_w (
      .clk(clk), .rst(rst), .en(en), .seed_load(seed_load),
      .seed_ch(seed_ch), .seed_data(seed_data),
      .rnd_out(out_w), .rnd_valid(val_w), .lockup_flag(lk_w)
   );

   pbit_rng_bank #(.WARMUP(0)) u_z (
      .clk(clk), .rst(rst), .en(en), .seed_load(seed_load),
      .seed_ch(seed_ch), .seed_data(seed_data),
      .rnd_out(out_z), .rnd_valid(val_z), .lockup_flag(lk_z)
   );

   int errs = 0;
   int checks = 0;

   // Reference model, index 0 = WARMUP 16, index 1 = WARMUP 0
   int          wu[2] = '{16, 0};
   logic [31:0] ms[2][4];
   int          wl[2];
   bit          lk[2][4];
   bit          zq[2][4];
   bit          dn[2][4];

   function automatic logic [31:0] mnext(input logic [31:0] s);
      int c = 0;
      for (int k = 0; k < 32; k++)
         if (TAPS[k] && s[k]) c++;
      return {s[30:0], (c % 2 == 0)};
   endfunction

   function automatic logic [31:0] filt(input logic [31:0] d);
      return (d == 32'hFFFF_FFFF) ? 32'hFFFF_FFFE : d;
   endfunction

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errs++;
         $display("FAIL %s: got %h expected %h", nm, a, e);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         wl[d] = wu[d];
         for (int c = 0; c < 4; c++) begin
            ms[d][c] = filt(32'd1 + 32'(c) * 32'h9E37_79B9);
            lk[d][c] = 1'b0;
            zq[d][c] = 1'b0;
            dn[d][c] = 1'b0;
         end
      end
   endtask

   task automatic model_step();
      for (int d = 0; d < 2; d++) begin
         bit stp;
         stp = (wl[d] > 0) || en;
         for (int c = 0; c < 4; c++) begin
            if (seed_load && int'(seed_ch) == c) begin
               ms[d][c] = filt(seed_data);
               if (seed_data == 32'hFFFF_FFFF) lk[d][c] = 1'b1;
               zq[d][c] = 1'b0;
               dn[d][c] = 1'b0;
            end else if (stp) begin
               logic [31:0] n;
               n = mnext(ms[d][c]);
`ifdef PBIT_RNG_ZERO_INSERT_EN
               if (zq[d][c]) begin
                  zq[d][c] = 1'b0;
                  ms[d][c] = n;
               end else if (n == 32'd3 && !dn[d][c]) begin
                  zq[d][c] = 1'b1;
                  dn[d][c] = 1'b1;
               end else begin
                  ms[d][c] = n;
               end
`else
               ms[d][c] = n;
`endif
            end
         end
         if (seed_load && wu[d] != 0) wl[d] = wu[d];
         else if (wl[d] > 0)          wl[d]--;
      end
   endtask

   task automatic check_all();
      for (int d = 0; d < 2; d++) begin
         logic [127:0] o;
         logic [3:0]   l, el;
         o = d ? out_z : out_w;
         l = d ? lk_z : lk_w;
         for (int c = 0; c < 4; c++) begin
            chk($sformatf("d%0d ch%0d word", d, c), o[c*32 +: 32],
                zq[d][c] ? 32'd0 : ms[d][c]);
            el[c] = lk[d][c];
         end
         chk($sformatf("d%0d valid", d), 32'(d ? val_z : val_w), 32'(wl[d] == 0));
         chk($sformatf("d%0d lockup", d), 32'(l), 32'(el));
      end
   endtask

   task automatic cyc();
      if (rst) model_reset();
      else     model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   typedef struct {
      bit          rst;
      bit          en;
      logic [31:0] exp;
   } vec_t;

   vec_t tv[5];

   initial begin
      logic [31:0] snap[4];
      logic [31:0] e;
      int          lo;

      // Test 1: WARMUP=0 instance, sequence from seed 1
      tv[0] = '{1'b1, 1'b0, 32'h1};
      tv[1] = '{1'b0, 1'b1, 32'h2};
      tv[2] = '{1'b0, 1'b1, 32'h4};
      tv[3] = '{1'b0, 1'b1, 32'h9};
      tv[4] = '{1'b0, 1'b0, 32'h9};
      #2;
      for (int i = 0; i < 5; i++) begin
         rst = tv[i].rst;
         en  = tv[i].en;
         cyc();
         chk($sformatf("t1 ch0 vec%0d", i), out_z[31:0], tv[i].exp);
         chk($sformatf("t1 valid vec%0d", i), 32'(val_z), 32'd1);
      end

      // Test 2: warm-up length and step count
      rst = 1'b1; en = 1'b0;
      cyc();
      rst = 1'b0;
      lo = 0;
      while (!val_w && lo < 40) begin
         lo++;
         cyc();
      end
      chk("t2 warm cycles", 32'(lo), 32'd16);
      e = 32'd1;
      for (int k = 0; k < 16; k++) e = mnext(e);
      chk("t2 ch0 after warm", out_w[31:0], e);

      // Test 3: en=0 holds, en=1 resumes with no skipped word
      for (int c = 0; c < 4; c++) snap[c] = out_w[c*32 +: 32];
      for (int k = 0; k < 10; k++) cyc();
      for (int c = 0; c < 4; c++)
         chk($sformatf("t3 hold ch%0d", c), out_w[c*32 +: 32], snap[c]);
      en = 1'b1;
      cyc();
      chk("t3 resume ch0", out_w[31:0], mnext(snap[0]));

      // Test 4: reseed ch2 with 1 during RUN
      seed_load = 1'b1; seed_ch = 2'd2; seed_data = 32'd1;
      cyc();
      seed_load = 1'b0;
      chk("t4 ch2 load", out_z[95:64], 32'h1);
      chk("t4 valid drop", 32'(val_w), 32'd0);
      cyc(); chk("t4 ch2 s1", out_z[95:64], 32'h2);
      cyc(); chk("t4 ch2 s2", out_z[95:64], 32'h4);
      cyc(); chk("t4 ch2 s3", out_z[95:64], 32'h9);
      for (int k = 0; k < 14; k++) cyc();

      // Test 5: all-ones seed rejected on ch1
      seed_load = 1'b1; seed_ch = 2'd1; seed_data = 32'hFFFF_FFFF;
      cyc();
      seed_load = 1'b0;
      chk("t5 ch1 safe", out_w[63:32], 32'hFFFF_FFFE);
      chk("t5 flag", 32'(lk_w), 32'h2);
      for (int k = 0; k < 20; k++) cyc();
      chk("t5 flag sticky", 32'(lk_z), 32'h2);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("t5 flag cleared", 32'(lk_w), 32'h0);

`ifdef PBIT_RNG_ZERO_INSERT_EN
      // Zero insertion just before state 'h3
      en = 1'b1;
      seed_load = 1'b1; seed_ch = 2'd0; seed_data = 32'h8000_0001;
      cyc();
      seed_load = 1'b0;
      cyc(); chk("zi zero word", out_z[31:0], 32'h0);
      cyc(); chk("zi then 3", out_z[31:0], 32'h3);
`endif

      // Randomised traffic against the model
      for (int k = 0; k < 400; k++) begin
         rst       = ($urandom % 150) == 0;
         en        = ($urandom % 4) != 0;
         seed_load = ($urandom % 20) == 0;
         seed_ch   = 2'($urandom % 4);
         seed_data = (($urandom % 4) == 0) ? 32'hFFFF_FFFF : $urandom;
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
